usb_rx_ctrl: RTL and testbench
==============================

Name: usb_rx_ctrl

Overview:
- Receive control FSM directly downstream of the USB RX bit timer and RX shift register.
- Consumes `shift_enable` / `byte_received` strobes, assembled bytes and the EOP flag.
- Drives `rx_transfer_active` back to the timer, validates SYNC/PID/length, and emits byte-store strobes and token fields to the RX FIFO / protocol layer.
- Reports packet type, good completion or error per packet.

Parameters:
- SYNC_BYTE, 8'h80, assembled value of a valid SYNC field.
- MAX_BYTES, 66, maximum bytes after PID in a DATA packet (64 payload + 2 CRC16).

Ports:
- clk  input  1  system clock
- n_rst  input  1  synchronous active-low reset
- d_edge  input  1  one-cycle pulse on any D+/D- transition (from edge detector)
- eop  input  1  SE0 present on bus (level)
- shift_enable  input  1  one-cycle bit-sample strobe from rx timer
- byte_received  input  1  one-cycle pulse; rcv_data valid in this same cycle
- rcv_data  input  8  assembled byte, LSB = first bit on wire
- rx_transfer_active  output  1  high while a packet is being received
- store_rx_data  output  1  one-cycle pulse: write rcv_data to RX FIFO
- flush  output  1  one-cycle pulse at start of each packet
- rx_packet  output  3  0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL
- rx_addr  output  7  token device address
- rx_endp  output  4  token endpoint
- rx_byte_count  output  7  bytes after PID in current/last packet
- rx_data_ready  output  1  one-cycle pulse: packet ended cleanly
- rx_error  output  1  sticky error flag

Behaviour:
- Reset: synchronous active-low; `n_rst`=0 sampled at a clk edge forces IDLE. All outputs are 0, including `rx_packet`=0. Applies mid-packet; no partial store strobes follow.
- States: IDLE, SYNC, PID, TOKEN, DATA, HSHK, EOP_WAIT, ERR_WAIT.
- IDLE to SYNC on `d_edge`:
  - `flush`=1 and `rx_error` cleared that cycle.
  - `rx_packet`, `rx_byte_count`, `rx_addr` and `rx_endp` cleared.
  - `rx_transfer_active` goes high the next cycle. It is high in every state except IDLE.
- SYNC, on `byte_received`:
  - `rcv_data`==SYNC_BYTE goes to PID.
  - Otherwise go to ERR_WAIT.
- PID, on `byte_received`:
  - Valid PIDs: low nibble in {0001, 1001, 0011, 1011, 0010, 1010, 1110} and high nibble == ~low nibble.
  - A valid PID loads `rx_packet` and goes to TOKEN (OUT/IN), DATA (DATA0/1) or HSHK (ACK/NAK/STALL).
  - Any other PID goes to ERR_WAIT.
- TOKEN:
  - 1st byte: `rx_addr`=`rcv_data[6:0]`, `rx_endp[0]`=`rcv_data[7]`.
  - 2nd byte: `rx_endp[3:1]`=`rcv_data[2:0]`.
  - A 3rd byte goes to ERR_WAIT.
- DATA:
  - Each `byte_received` pulses `store_rx_data` in the same cycle (combinational from state & `byte_received`) and increments `rx_byte_count`.
  - Byte number MAX_BYTES+1 goes to ERR_WAIT with no store.
- HSHK: any `byte_received` goes to ERR_WAIT.
- `rx_byte_count` counts every byte after the PID in TOKEN/DATA/HSHK and saturates at 127.
- Alignment flag:
  - Set on `byte_received`.
  - Cleared on `shift_enable` & !`eop` & !`byte_received`.
  - Set on entry to SYNC.
- EOP detect = `eop` & `shift_enable`, evaluated in SYNC/PID/TOKEN/DATA/HSHK:
  - Error if not aligned.
  - Error in SYNC or PID.
  - Error in TOKEN with count≠2.
  - Error in HSHK with count≠0.
  - DATA with count<2 is an error.
  - Otherwise go to EOP_WAIT.
- EOP_WAIT: on `d_edge` (SE0 to J), pulse `rx_data_ready`, then IDLE.
- ERR_WAIT:
  - `rx_error`=1 from entry and held until the next IDLE to SYNC.
  - Exit to IDLE on the first cycle with `eop`=0 and `d_edge`=1 after an EOP detect has been seen.
  - A bare `d_edge` while bus activity continues stays in ERR_WAIT.
- Simultaneous `byte_received` and EOP detect: the byte is processed first, EOP is then judged with aligned=1 and the updated count. If the byte itself causes an error, the error wins.
- `d_edge` outside IDLE/EOP_WAIT/ERR_WAIT is ignored by the FSM.

Decomposition:
- Package `usb_rx_pkg`:
  - PID nibble constants.
  - `rx_packet` code enum (3-bit).
  - FSM state enum.
  - SYNC_BYTE default.
- Sub-module `usb_pid_decode`:
  - Combinational.
  - Input: 8-bit byte.
  - Outputs: `pid_valid` and 3-bit packet code.

Test Plan:
- ACK: SYNC 8'h80, PID 8'hD2, aligned EOP, `d_edge` -> `rx_packet`=5, `rx_byte_count`=0, one `rx_data_ready` pulse, `rx_error`=0, `rx_transfer_active` low after.
- OUT token: 8'h80, 8'hE1, 8'hA5, 8'h03, EOP -> `rx_packet`=1, `rx_addr`=7'h25, `rx_endp`=4'h7, `rx_data_ready` pulse.
- DATA0: PID 8'hC3 then 4 bytes 8'h11..8'h44, EOP -> exactly 4 `store_rx_data` pulses coincident with `byte_received`, `rx_byte_count`=4; `flush` pulsed once at packet start.
- Bad PID 8'hC2 (complement mismatch) -> `rx_error`=1 held through rest of packet and bus idle; no `store_rx_data`; next good packet clears `rx_error` with `flush`.
- EOP after 3 bits of a DATA byte -> ERR_WAIT, `rx_error`=1, no `rx_data_ready`.
- DATA with 67 bytes -> 66 stores, `rx_error`=1 on the 67th. Synchronous `n_rst` low mid-DATA -> all outputs 0 next edge, IDLE.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// USB RX control shared types: PID nibbles, packet codes, FSM states.
// Imported by the RX control FSM and the PID decoder.
package usb_rx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
    localparam int         MAX_BYTES_DEF = 66;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_OUT   = 3'd1,
        PKT_IN    = 3'd2,
        PKT_DATA0 = 3'd3,
        PKT_DATA1 = 3'd4,
        PKT_ACK   = 3'd5,
        PKT_NAK   = 3'd6,
        PKT_STALL = 3'd7
    } rx_pkt_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_TOKEN,
        S_DATA,
        S_HSHK,
        S_EOPW,
        S_ERRW
    } rx_state_e;

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// Bundle between RX timer/shift register, RX control and the FIFO side.
// slave = RX control, master = whatever drives the receive strobes.
interface usb_rx_ctrl_if;

    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;

    logic       rx_transfer_active;
    logic       store_rx_data;
    logic       flush;
    logic [2:0] rx_packet;
    logic [6:0] rx_addr;
    logic [3:0] rx_endp;
    logic [6:0] rx_byte_count;
    logic       rx_data_ready;
    logic       rx_error;

    modport master (
        output d_edge, eop, shift_enable, byte_received, rcv_data,
        input  rx_transfer_active, store_rx_data, flush, rx_packet,
        input  rx_addr, rx_endp, rx_byte_count, rx_data_ready, rx_error
    );

    modport slave (
        input  d_edge, eop, shift_enable, byte_received, rcv_data,
        output rx_transfer_active, store_rx_data, flush, rx_packet,
        output rx_addr, rx_endp, rx_byte_count, rx_data_ready, rx_error
    );

endinterface

// File: rtl/usb_pid_decode.sv
// Combinational PID check: known low nibble and high nibble == ~low.
// pkt is only meaningful while pid_valid is high.
module usb_pid_decode
    import usb_rx_pkg::*;
(
    input  logic [7:0] pid,
    output logic       pid_valid,
    output rx_pkt_e    pkt
);

    logic [3:0] lo;

    assign lo = pid[3:0];

    always_comb begin
        pkt = PKT_NONE;
        unique case (1'b1)
            (lo == PID_OUT):   pkt = PKT_OUT;
            (lo == PID_IN):    pkt = PKT_IN;
            (lo == PID_DATA0): pkt = PKT_DATA0;
            (lo == PID_DATA1): pkt = PKT_DATA1;
            (lo == PID_ACK):   pkt = PKT_ACK;
            (lo == PID_NAK):   pkt = PKT_NAK;
            (lo == PID_STALL): pkt = PKT_STALL;
            default:           pkt = PKT_NONE;
        endcase
        pid_valid = (pkt != PKT_NONE) && (pid[7:4] == ~lo);
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB receive control FSM: SYNC/PID/length checks, FIFO store strobes,
// token field capture and per-packet good/error reporting.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic           clk,
    input  logic           n_rst,
    usb_rx_ctrl_if.slave   bus
);

    rx_state_e  state, state_n;
    logic [2:0] pkt_q, pkt_n;
    logic [6:0] addr_q, addr_n;
    logic [3:0] endp_q, endp_n;
    logic [6:0] cnt_q, cnt_n, cnt_inc;
    logic       err_q, err_n;
    logic       algn_q, algn_n;
    logic       seen_q, seen_n;
    logic       store, flush, rdy, eop_det;
    logic       pid_valid;
    rx_pkt_e    pid_pkt;

    usb_pid_decode u_pid (
        .pid       (bus.rcv_data),
        .pid_valid (pid_valid),
        .pkt       (pid_pkt)
    );

    assign eop_det = bus.eop & bus.shift_enable;
    assign cnt_inc = (cnt_q == 7'h7f) ? cnt_q : cnt_q + 7'd1;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state  <= S_IDLE;
            pkt_q  <= '0;
            addr_q <= '0;
            endp_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            algn_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            state  <= state_n;
            pkt_q  <= pkt_n;
            addr_q <= addr_n;
            endp_q <= endp_n;
            cnt_q  <= cnt_n;
            err_q  <= err_n;
            algn_q <= algn_n;
            seen_q <= seen_n;
        end
    end

    always_comb begin
        state_n = state;
        pkt_n   = pkt_q;
        addr_n  = addr_q;
        endp_n  = endp_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        seen_n  = seen_q;
        algn_n  = algn_q;
        store   = 1'b0;
        flush   = 1'b0;
        rdy     = 1'b0;

        // algn_n is the alignment after this cycle's byte, used by EOP checks
        if (bus.byte_received)
            algn_n = 1'b1;
        else if (bus.shift_enable && !bus.eop)
            algn_n = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.d_edge) begin
                    state_n = S_SYNC;
                    flush   = 1'b1;
                    pkt_n   = PKT_NONE;
                    addr_n  = '0;
                    endp_n  = '0;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                    seen_n  = 1'b0;
                    algn_n  = 1'b1;
                end
            end
            S_SYNC: begin
                if (eop_det)
                    state_n = S_ERRW;
                else if (bus.byte_received)
                    state_n = (bus.rcv_data == SYNC_BYTE) ? S_PID : S_ERRW;
            end
            S_PID: begin
                if (eop_det || (bus.byte_received && !pid_valid)) begin
                    state_n = S_ERRW;
                end else if (bus.byte_received) begin
                    pkt_n = pid_pkt;
                    unique case (pid_pkt)
                        PKT_OUT, PKT_IN:     state_n = S_TOKEN;
                        PKT_DATA0, PKT_DATA1: state_n = S_DATA;
                        default:             state_n = S_HSHK;
                    endcase
                end
            end
            S_TOKEN: begin
                if (bus.byte_received) begin
                    cnt_n = cnt_inc;
                    if (cnt_q == 7'd0) begin
                        addr_n    = bus.rcv_data[6:0];
                        endp_n[0] = bus.rcv_data[7];
                    end else if (cnt_q == 7'd1) begin
                        endp_n[3:1] = bus.rcv_data[2:0];
                    end else begin
                        state_n = S_ERRW;
                    end
                end
                if (eop_det && state_n != S_ERRW)
                    state_n = (algn_n && cnt_n == 7'd2) ? S_EOPW : S_ERRW;
            end
            S_DATA: begin
                if (bus.byte_received) begin
                    cnt_n = cnt_inc;
                    if (cnt_q >= 7'(MAX_BYTES))
                        state_n = S_ERRW;
                    else
                        store = 1'b1;
                end
                if (eop_det && state_n != S_ERRW)
                    state_n = (algn_n && cnt_n >= 7'd2) ? S_EOPW : S_ERRW;
            end
            S_HSHK: begin
                if (bus.byte_received) begin
                    cnt_n   = cnt_inc;
                    state_n = S_ERRW;
                end
                if (eop_det && state_n != S_ERRW)
                    state_n = (algn_n && cnt_n == 7'd0) ? S_EOPW : S_ERRW;
            end
            S_EOPW: begin
                if (bus.d_edge) begin
                    rdy     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_ERRW: begin
                if (eop_det)
                    seen_n = 1'b1;
                if (!bus.eop && bus.d_edge && seen_q)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (state != S_ERRW && state_n == S_ERRW) begin
            err_n  = 1'b1;
            seen_n = eop_det;
        end
    end

    assign bus.rx_transfer_active = (state != S_IDLE);
    assign bus.store_rx_data      = store;
    assign bus.flush              = flush;
    assign bus.rx_data_ready      = rdy;
    assign bus.rx_packet          = pkt_q;
    assign bus.rx_addr            = addr_q;
    assign bus.rx_endp            = endp_q;
    assign bus.rx_byte_count      = cnt_q;
    assign bus.rx_error           = err_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: packet vector table plus
// hand-written error, overflow and mid-packet reset sequences.
module tb_usb_rx_ctrl;

    logic clk;
    logic n_rst;
    int   n_chk;
    int   n_fail;
    int   n_store;
    int   n_flush;
    int   n_rdy;
    int   n_bad_store;
    logic [7:0] stored[$];

    usb_rx_ctrl_if bus ();

    usb_rx_ctrl dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sync;
        logic [7:0] pid;
        int         nb;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [2:0] pkt;
        logic       err;
        logic [6:0] cnt;
        logic [6:0] addr;
        logic [3:0] endp;
        int         st;
        int         rdy;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic de, input logic e, input logic se,
                       input logic br, input logic [7:0] d);
        bus.d_edge        = de;
        bus.eop           = e;
        bus.shift_enable  = se;
        bus.byte_received = br;
        bus.rcv_data      = d;
        @(negedge clk);
        if (bus.store_rx_data) begin
            n_store++;
            stored.push_back(bus.rcv_data);
            if (!bus.byte_received) n_bad_store++;
        end
        if (bus.flush) n_flush++;
        if (bus.rx_data_ready) n_rdy++;
        @(posedge clk);
        #1;
        bus.d_edge        = 1'b0;
        bus.eop           = 1'b0;
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        bus.rcv_data      = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, b);
    endtask

    task automatic send_eop();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clr_counts();
        n_store = 0;
        n_flush = 0;
        n_rdy   = 0;
        stored.delete();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        n_bad_store = 0;
        clr_counts();
        bus.d_edge = 0;
        bus.eop = 0;
        bus.shift_enable = 0;
        bus.byte_received = 0;
        bus.rcv_data = 0;
        n_rst = 1'b0;

        vt[0]  = '{8'h80, 8'hD2, 0, 8'h00, 8'h00, 3'd5, 1'b0, 7'd0, 7'h00, 4'h0, 0, 1};
        vt[1]  = '{8'h80, 8'hE1, 2, 8'hA5, 8'h03, 3'd1, 1'b0, 7'd2, 7'h25, 4'h7, 0, 1};
        vt[2]  = '{8'h80, 8'h69, 2, 8'h8A, 8'h05, 3'd2, 1'b0, 7'd2, 7'h0A, 4'hB, 0, 1};
        vt[3]  = '{8'h80, 8'h5A, 0, 8'h00, 8'h00, 3'd6, 1'b0, 7'd0, 7'h00, 4'h0, 0, 1};
        vt[4]  = '{8'h80, 8'h1E, 0, 8'h00, 8'h00, 3'd7, 1'b0, 7'd0, 7'h00, 4'h0, 0, 1};
        vt[5]  = '{8'h80, 8'h4B, 2, 8'hDE, 8'hAD, 3'd4, 1'b0, 7'd2, 7'h00, 4'h0, 2, 1};
        vt[6]  = '{8'h80, 8'hC2, 2, 8'h11, 8'h22, 3'd0, 1'b1, 7'd0, 7'h00, 4'h0, 0, 0};
        vt[7]  = '{8'h80, 8'hD2, 1, 8'h12, 8'h00, 3'd5, 1'b1, 7'd1, 7'h00, 4'h0, 0, 0};
        vt[8]  = '{8'h80, 8'hE1, 1, 8'hA5, 8'h00, 3'd1, 1'b1, 7'd1, 7'h25, 4'h1, 0, 0};
        vt[9]  = '{8'h80, 8'hC3, 1, 8'h77, 8'h00, 3'd3, 1'b1, 7'd1, 7'h00, 4'h0, 1, 0};
        vt[10] = '{8'h81, 8'hD2, 0, 8'h00, 8'h00, 3'd0, 1'b1, 7'd0, 7'h00, 4'h0, 0, 0};
        vt[11] = '{8'h80, 8'hF0, 0, 8'h00, 8'h00, 3'd0, 1'b1, 7'd0, 7'h00, 4'h0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_active", 32'(bus.rx_transfer_active), 0);
        chk("rst_packet", 32'(bus.rx_packet), 0);
        chk("rst_count", 32'(bus.rx_byte_count), 0);
        chk("rst_error", 32'(bus.rx_error), 0);
        chk("rst_addr", 32'(bus.rx_addr), 0);
        chk("rst_endp", 32'(bus.rx_endp), 0);
        n_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        for (int v = 0; v < 12; v++) begin
            clr_counts();
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            chk($sformatf("v%0d_active", v), 32'(bus.rx_transfer_active), 1);
            send_byte(vt[v].sync);
            send_byte(vt[v].pid);
            if (vt[v].nb > 0) send_byte(vt[v].b0);
            if (vt[v].nb > 1) send_byte(vt[v].b1);
            send_eop();
            chk($sformatf("v%0d_packet", v), 32'(bus.rx_packet), 32'(vt[v].pkt));
            chk($sformatf("v%0d_count", v), 32'(bus.rx_byte_count), 32'(vt[v].cnt));
            chk($sformatf("v%0d_addr", v), 32'(bus.rx_addr), 32'(vt[v].addr));
            chk($sformatf("v%0d_endp", v), 32'(bus.rx_endp), 32'(vt[v].endp));
            chk($sformatf("v%0d_error", v), 32'(bus.rx_error), 32'(vt[v].err));
            chk($sformatf("v%0d_stores", v), 32'(n_store), 32'(vt[v].st));
            chk($sformatf("v%0d_ready", v), 32'(n_rdy), 32'(vt[v].rdy));
            chk($sformatf("v%0d_flush", v), 32'(n_flush), 1);
            chk($sformatf("v%0d_idle", v), 32'(bus.rx_transfer_active), 0);
        end

        // DATA0 with four payload bytes
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_eop();
        chk("d0_stores", 32'(n_store), 4);
        chk("d0_count", 32'(bus.rx_byte_count), 4);
        chk("d0_flush", 32'(n_flush), 1);
        chk("d0_ready", 32'(n_rdy), 1);
        chk("d0_packet", 32'(bus.rx_packet), 3);
        chk("d0_error", 32'(bus.rx_error), 0);
        chk("d0_qlen", 32'(stored.size()), 4);
        if (stored.size() == 4) begin
            chk("d0_byte0", 32'(stored[0]), 32'h11);
            chk("d0_byte3", 32'(stored[3]), 32'h44);
        end

        // bad PID, bare edge mid-packet, then a good packet clears the error
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'h80);
        send_byte(8'hC2);
        chk("bp_err_entry", 32'(bus.rx_error), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("bp_bare_edge_active", 32'(bus.rx_transfer_active), 1);
        chk("bp_bare_edge_err", 32'(bus.rx_error), 1);
        send_byte(8'h99);
        send_eop();
        chk("bp_err_idle", 32'(bus.rx_error), 1);
        chk("bp_idle", 32'(bus.rx_transfer_active), 0);
        chk("bp_stores", 32'(n_store), 0);
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("bp_flush", 32'(n_flush), 1);
        chk("bp_err_cleared", 32'(bus.rx_error), 0);
        send_byte(8'h80);
        send_byte(8'hD2);
        send_eop();
        chk("bp_ack_ready", 32'(n_rdy), 1);
        chk("bp_ack_err", 32'(bus.rx_error), 0);

        // EOP after three bits of a DATA byte
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'hAB);
        send_byte(8'hCD);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        send_eop();
        chk("ua_error", 32'(bus.rx_error), 1);
        chk("ua_ready", 32'(n_rdy), 0);
        chk("ua_stores", 32'(n_store), 2);
        chk("ua_idle", 32'(bus.rx_transfer_active), 0);

        // 67-byte DATA1: 66 stores, error on the last byte
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'h80);
        send_byte(8'h4B);
        for (int i = 0; i < 66; i++) send_byte(8'(i));
        chk("ov_err_before", 32'(bus.rx_error), 0);
        chk("ov_count66", 32'(bus.rx_byte_count), 66);
        send_byte(8'hEE);
        chk("ov_err_67", 32'(bus.rx_error), 1);
        chk("ov_stores", 32'(n_store), 66);
        send_eop();
        chk("ov_ready", 32'(n_rdy), 0);

        // synchronous reset in the middle of a DATA packet
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h5A);
        send_byte(8'hA5);
        n_rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("mr_active", 32'(bus.rx_transfer_active), 0);
        chk("mr_packet", 32'(bus.rx_packet), 0);
        chk("mr_count", 32'(bus.rx_byte_count), 0);
        chk("mr_error", 32'(bus.rx_error), 0);
        chk("mr_addr", 32'(bus.rx_addr), 0);
        chk("mr_endp", 32'(bus.rx_endp), 0);
        n_rst = 1'b1;
        send_byte(8'h3C);
        chk("mr_stores", 32'(n_store), 2);
        chk("mr_still_idle", 32'(bus.rx_transfer_active), 0);
        chk("mr_no_ready", 32'(n_rdy), 0);

        chk("store_with_byte", 32'(n_bad_store), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
